// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: opcode and FSM state enums, plus
// the 7-segment digit lookup used by the signed display decoder.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_UMUL = 2'd2,
    OP_SMUL = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  // gfedcba segment pattern for a decimal digit; blank for anything else
  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    seg_digit = 7'h3F;
      4'd1:    seg_digit = 7'h06;
      4'd2:    seg_digit = 7'h5B;
      4'd3:    seg_digit = 7'h4F;
      4'd4:    seg_digit = 7'h66;
      4'd5:    seg_digit = 7'h6D;
      4'd6:    seg_digit = 7'h7D;
      4'd7:    seg_digit = 7'h07;
      4'd8:    seg_digit = 7'h7F;
      4'd9:    seg_digit = 7'h6F;
      default: seg_digit = 7'h00;
    endcase
  endfunction

endpackage

// File: rtl/seg7_signed.sv
// Signed value to single-digit 7-segment image: bit7 is the minus sign,
// bits6:0 the digit. Values outside -9..9 show only the sign bar (80h).
module seg7_signed
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] val_i,
  output logic [7:0]   seg_o
);

  logic signed [31:0] v;
  logic signed [31:0] mag;

  assign v   = 32'($signed(val_i));
  assign mag = (v < 0) ? -v : v;

  always_comb begin
    seg_o = 8'h80;
    if (mag <= 32'sd9) seg_o = {v < 0, seg_digit(4'(mag))};
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/sub with signed overflow, iterative
// shift-add multiply (unsigned, or signed via magnitudes plus a fix-up cycle).
module seq_alu
  import alu_pkg::*;
#(
  parameter int NBITS = 4
) (
  input  logic                 clk_2,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [NBITS-1:0]     a,
  input  logic [NBITS-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*NBITS-1:0]   result,
  output logic                 overflow,
  output logic [7:0]           seg
);

  localparam int MSB_RES = 2*NBITS-1;
  localparam int CW      = $clog2(NBITS+1);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [MSB_RES:0]   mcand_q, mcand_d;
  logic [NBITS-1:0]   mplier_q, mplier_d;
  logic [MSB_RES:0]   acc_q, acc_d;
  logic               neg_q, neg_d;
  logic [MSB_RES:0]   result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic [MSB_RES:0]   sa, sb, addsub, acc_add;
  logic [NBITS-1:0]   mag_a, mag_b;
  logic               is_smul, last;

  assign sa      = {{NBITS{a[NBITS-1]}}, a};
  assign sb      = {{NBITS{b[NBITS-1]}}, b};
  assign addsub  = (op_e'(op) == OP_SUB) ? (sa - sb) : (sa + sb);
  assign is_smul = (op_e'(op) == OP_SMUL);
  // -2^(NBITS-1) negates to itself, which read unsigned is the right magnitude
  assign mag_a   = (is_smul && a[NBITS-1]) ? -a : a;
  assign mag_b   = (is_smul && b[NBITS-1]) ? -b : b;
  assign acc_add = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last    = (cnt_q == CW'(NBITS-1));

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d = op_e'(op);
          if (op_e'(op) == OP_ADD || op_e'(op) == OP_SUB) begin
            result_d = addsub;
            // in range iff the top NBITS+1 bits are all copies of the sign
            ovf_d    = !((&addsub[MSB_RES:NBITS-1]) || !(|addsub[MSB_RES:NBITS-1]));
            done_d   = 1'b1;
          end else begin
            mcand_d  = {{NBITS{1'b0}}, mag_a};
            mplier_d = mag_b;
            acc_d    = '0;
            cnt_d    = '0;
            neg_d    = is_smul && (a[NBITS-1] ^ b[NBITS-1]);
            state_d  = S_MUL;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_add;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (last) begin
          if (op_q == OP_SMUL) begin
            state_d = S_FIX;
          end else begin
            state_d  = S_IDLE;
            result_d = acc_add;
            ovf_d    = 1'b0;
            done_d   = 1'b1;
          end
        end
      end
      S_FIX: begin
        result_d = neg_q ? -acc_q : acc_q;
        ovf_d    = 1'b0;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = ovf_q;

  seg7_signed #(.W(2*NBITS)) u_seg (
    .val_i (result_q),
    .seg_o (seg)
  );

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter NBITS, default 4, legal 2..16: operand width.
REQ-002 SHALL have parameter MSB_RES, derived 2*NBITS-1: result MSB, not overridable.
REQ-003 SHALL have port clk_2, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-006 SHALL have port op, input, 2 bits: 0 add, 1 sub, 2 unsigned mul, 3 signed mul.
REQ-007 SHALL have ports a and b, input, NBITS each: operands; signed for ops 0/1/3, unsigned for op 2.
REQ-008 SHALL have port busy, output, 1 bit: operation in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when result and overflow are updated.
REQ-010 SHALL have port result, output, 2*NBITS: registered exact result, held until next completion.
REQ-011 SHALL have port overflow, output, 1 bit: add/sub result outside signed NBITS range.
REQ-012 SHALL have port seg, output, 8 bits: 7-segment image of result; bit7 minus sign, bits6:0 gfedcba.

Function
REQ-013 SHALL capture a, b, op into internal registers on the edge where state=IDLE and start=1; inputs are ignored otherwise.
REQ-014 SHALL use states IDLE, MUL, FIX; IDLE->MUL on accepted op 2/3; MUL->FIX after NBITS iterations if op 3; MUL->IDLE after NBITS iterations if op 2; FIX->IDLE after one cycle.
REQ-015 SHALL complete add/sub without leaving IDLE: result, overflow and done=1 registered on the accepting edge (latency 1).
REQ-016 SHALL compute add/sub exactly in 2*NBITS bits (sign-extended operands), never wrapped.
REQ-017 SHALL set overflow=1 iff the add/sub result is < -2^(NBITS-1) or > 2^(NBITS-1)-1; overflow=0 for multiplies.
REQ-018 SHALL perform multiplication by iterative shift-add, one multiplier bit per cycle, with a counter of ceil(log2(NBITS+1)) bits.
REQ-019 SHALL run signed multiply on operand magnitudes and negate the product in FIX when operand signs differ; latency NBITS+1 edges from acceptance.
REQ-020 SHALL give unsigned multiply a latency of NBITS edges from acceptance.
REQ-021 SHALL drive busy=1 whenever state is MUL or FIX, else 0.
REQ-022 SHALL assert done for exactly the single cycle following each completion edge.
REQ-023 SHALL accept a new start in the cycle done=1, since state is already IDLE.
REQ-024 SHALL handle the -2^(NBITS-1) operand correctly (magnitude 2^(NBITS-1) fits the unsigned iteration path).
REQ-025 SHALL derive seg combinationally from result: for signed value -9..9, bit7 = sign, bits6:0 = digit code (0 3F,1 06,2 5B,3 4F,4 66,5 6D,6 7D,7 07,8 7F,9 6F); outside that range seg=80h.

Reset
REQ-026 SHALL on reset=1 at an edge force state IDLE, counter 0, busy 0, done 0, result 0, overflow 0, regardless of state; seg therefore 3Fh.
REQ-027 SHALL abort any multiply in progress on reset without asserting done.
REQ-028 SHALL give reset priority over start on the same edge.

Structure
REQ-029 SHALL place the op encoding enum and the state enum in shared package alu_pkg.
REQ-030 SHALL place the signed-value-to-segment decoder in sub-module seg7_signed, instantiated once.

Verification (NBITS=4)
REQ-031 SHALL test add a=7,b=1: done one edge after acceptance, result=08h, overflow=1, seg=7Fh.
REQ-032 SHALL test sub a=-8,b=1: result=F7h, overflow=1, seg=EFh; sub a=2,b=3: result=FFh, overflow=0, seg=86h.
REQ-033 SHALL test unsigned mul a=15,b=15: busy for 4 cycles, done at edge 4, result=E1h, seg=80h.
REQ-034 SHALL test signed mul a=-8,b=-8: result=40h at edge 5; a=-3,b=3: result=F7h, seg=EFh.
REQ-035 SHALL test start pulses and operand changes during busy: ignored, result unchanged, a back-to-back start in the done cycle accepted.
REQ-036 SHALL test reset asserted in cycle 2 of a multiply: outputs zero next edge, no done pulse, next add completes normally.
